// File: rtl/text_video_pkg.sv
// Shared constants and helpers for the character-cell video generator.
// Holds default raster totals, text-window size helpers and the code-to-glyph mapping.
// Pure declarations; no timing or flow control of its own.
package text_video_pkg;

    function automatic int timing_total(input int vis, input int front,
                                        input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic int win_width(input int cols, input int x_scale);
        return cols * 8 * x_scale;
    endfunction

    function automatic int win_height(input int rows, input int font_lines,
                                      input int y_scale);
        return rows * font_lines * y_scale;
    endfunction

    // Totals and window size for the default 640x480, 32x16 configuration
    localparam int H_TOTAL = timing_total(640, 16, 96, 48);
    localparam int V_TOTAL = timing_total(480, 10, 2, 33);
    localparam int WIN_W   = win_width(32, 2);
    localparam int WIN_H   = win_height(16, 13, 2);

    // Fold the 256 character codes onto the 128 glyphs of the font image.
    // Every branch lands below 128, so only seven bits are returned.
    function automatic logic [6:0] char_map(input logic [7:0] c);
        logic [7:0] m;
        if ((c >= 8'd64 && c <= 8'd95) || (c >= 8'd128 && c <= 8'd191))
            m = c - 8'd64;
        else if (c >= 8'd192)
            m = c - 8'd128;
        else
            m = c;
        return m[6:0];
    endfunction

endpackage

// File: rtl/text_video_gen_if.sv
// CPU character-RAM port, colour inputs and LCD pixel outputs of the video generator.
// Latency set by the modules on either side (CPU read 1 clk, pixels 3 clk).
// No backpressure: the raster free-runs and the CPU port accepts every strobe.
interface text_video_gen_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          rd_ram;
    logic          wr_ram;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    ram_out;
    logic [DW-1:0] fg_color;
    logic [DW-1:0] bg_color;
    logic [DW-1:0] lcd_dat;
    logic          lcd_hsync;
    logic          lcd_vsync;
    logic          lcd_den;
    logic          frame_irq;
`ifdef TEXT_VIDEO_CURSOR_EN
    logic [AW-1:0] cursor_addr;
    logic          cursor_on;
`endif

    modport master (
`ifdef TEXT_VIDEO_CURSOR_EN
        output cursor_addr, cursor_on,
`endif
        output rd_ram, wr_ram, addr, data, fg_color, bg_color,
        input  ram_out, lcd_dat, lcd_hsync, lcd_vsync, lcd_den, frame_irq
    );

    modport slave (
`ifdef TEXT_VIDEO_CURSOR_EN
        input  cursor_addr, cursor_on,
`endif
        input  rd_ram, wr_ram, addr, data, fg_color, bg_color,
        output ram_out, lcd_dat, lcd_hsync, lcd_vsync, lcd_den, frame_irq
    );
endinterface

// File: rtl/font_rom.sv
// 2048x8 glyph ROM addressed by {font_line[3:0], char[6:0]}, glyphs stored inverted.
// Latency: 1 clk (registered output).
// No backpressure: one lookup per clock.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data_out
);
    // Glyph image: code 0x20 is blank (all ones); any other code shows its
    // code bits XOR the line number in the upper nibble, stored inverted.
    function automatic logic [7:0] glyph(input logic [10:0] a);
        logic [6:0] code;
        logic [3:0] line;
        code = a[6:0];
        line = a[10:7];
        if (code == 7'h20)
            return 8'hFF;
        return ~({1'b0, code} ^ {line, 4'b0000});
    endfunction

    // Registered lookup
    always_ff @(posedge clk) begin
        data_out <= glyph(addr);
    end
endmodule

// File: rtl/text_video_gen.sv
// Character-cell video generator: CPU-shared char RAM, glyph mapper, font ROM, raster timing.
// Latency: 3 clk from raster counter to pins; CPU reads return 1 clk after rd_ram.
// No backpressure: the raster free-runs. Optional blinking cursor under TEXT_VIDEO_CURSOR_EN.
module text_video_gen
    import text_video_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int ROWS       = 16,
    parameter int FONT_LINES = 13,
    parameter int X_SCALE    = 2,
    parameter int Y_SCALE    = 2,
    parameter int X_OFFSET   = 64,
    parameter int Y_OFFSET   = 32,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter bit DE_POL     = 1'b1,
    parameter int DW         = 8,
    parameter int AW         = 11
)(
    input  logic            clk,
    input  logic            reset,
    text_video_gen_if.slave bus
);
    localparam int HT = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int VT = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int WW = win_width(COLS, X_SCALE);
    localparam int WH = win_height(ROWS, FONT_LINES, Y_SCALE);
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [7:0]    mem [2**AW];

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [1:0]    xs, ys;
    logic [2:0]    bit0;
    logic [CW-1:0] col;
    logic [3:0]    fline;
    logic [AW-1:0] row_base, scan_addr;
    int            hi, vi;
    logic          h_end, v_end, x_win, y_win, win0, de0, hs0, vs0, irq0, cur0;

    logic [7:0]    char_q;
    logic [3:0]    line1;
    logic [2:0]    bit1, bit2;
    logic          win1, de1, hs1, vs1, irq1, cur1;
    logic          win2, de2, hs2, vs2, irq2, cur2;
    logic [10:0]   rom_addr;
    logic [7:0]    rom_dat, glyph;
    logic          pix;

    // Raster position decode: window, sync, DE and frame-interrupt flags for stage 0
    always_comb begin
        hi        = int'(h);
        vi        = int'(v);
        h_end     = (hi == HT - 1);
        v_end     = (vi == VT - 1);
        x_win     = (hi >= X_OFFSET) && (hi < X_OFFSET + WW);
        y_win     = (vi >= Y_OFFSET) && (vi < Y_OFFSET + WH);
        win0      = x_win && y_win;
        de0       = (hi < H_VISIBLE) && (vi < V_VISIBLE);
        hs0       = (hi >= H_VISIBLE + H_FRONT) && (hi < H_VISIBLE + H_FRONT + H_SYNC);
        vs0       = (vi >= V_VISIBLE + V_FRONT) && (vi < V_VISIBLE + V_FRONT + V_SYNC);
        irq0      = (hi == 0) && (vi == V_VISIBLE);
        scan_addr = row_base + AW'(col);
    end

    // Raster counters: h wraps at the line end and steps v
    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_end ? '0 : h + 1'b1;
            if (h_end)
                v <= v_end ? '0 : v + 1'b1;
        end
    end

    // Horizontal cell counters advance inside the window and sit at zero elsewhere,
    // so they are already cleared when the next line's window opens
    always_ff @(posedge clk) begin
        if (reset || !x_win) begin
            xs   <= '0;
            bit0 <= '0;
            col  <= '0;
        end else if (int'(xs) == X_SCALE - 1) begin
            xs   <= '0;
            bit0 <= bit0 + 3'd1;
            if (bit0 == 3'd7)
                col <= col + 1'b1;
        end else begin
            xs <= xs + 2'd1;
        end
    end

    // Vertical cell counters step once per line end, same clear-outside-window scheme
    always_ff @(posedge clk) begin
        if (reset) begin
            ys       <= '0;
            fline    <= '0;
            row_base <= '0;
        end else if (h_end) begin
            if (!y_win) begin
                ys       <= '0;
                fline    <= '0;
                row_base <= '0;
            end else if (int'(ys) == Y_SCALE - 1) begin
                ys <= '0;
                if (int'(fline) == FONT_LINES - 1) begin
                    fline    <= '0;
                    row_base <= row_base + AW'(COLS);
                end else begin
                    fline <= fline + 4'd1;
                end
            end else begin
                ys <= ys + 2'd1;
            end
        end
    end

`ifdef TEXT_VIDEO_CURSOR_EN
    logic [4:0] frame_cnt;

    // Frame counter whose bit 4 blinks the cursor every 16 frames
    always_ff @(posedge clk) begin
        if (reset)
            frame_cnt <= '0;
        else if (h_end && v_end)
            frame_cnt <= frame_cnt + 5'd1;
    end

    assign cur0 = bus.cursor_on && (scan_addr == bus.cursor_addr) && frame_cnt[4];
`else
    assign cur0 = 1'b0;
`endif

    // CPU write port; RAM contents survive reset
    always_ff @(posedge clk) begin
        if (bus.wr_ram)
            mem[bus.addr] <= bus.data;
    end

    // CPU read port: registered, holds when idle, returns pre-write data on a same-cycle write
    always_ff @(posedge clk) begin
        if (reset)
            bus.ram_out <= '0;
        else if (bus.rd_ram)
            bus.ram_out <= mem[bus.addr];
    end

    // Stage 1 scan read: a same-cycle CPU write is not visible here
    always_ff @(posedge clk) begin
        char_q <= mem[scan_addr];
    end

    // Stage 1 side-band delay
    always_ff @(posedge clk) begin
        if (reset) begin
            {line1, bit1, win1, de1, hs1, vs1, irq1, cur1} <= '0;
        end else begin
            {line1, bit1, win1, de1, hs1, vs1, irq1, cur1} <=
                {fline, bit0, win0, de0, hs0, vs0, irq0, cur0};
        end
    end

    assign rom_addr = {line1, char_map(char_q)};

    font_rom u_font_rom (
        .clk      (clk),
        .addr     (rom_addr),
        .data_out (rom_dat)
    );

    // Stage 2 side-band delay, aligned with the registered ROM output
    always_ff @(posedge clk) begin
        if (reset) begin
            {bit2, win2, de2, hs2, vs2, irq2, cur2} <= '0;
        end else begin
            {bit2, win2, de2, hs2, vs2, irq2, cur2} <=
                {bit1, win1, de1, hs1, vs1, irq1, cur1};
        end
    end

    // Glyph bit select; a ROM one means background because glyphs are stored inverted
    always_comb begin
        glyph = rom_dat ^ {8{cur2}};
        pix   = glyph[bit2];
    end

    // Stage 3 output register with sync/DE polarity applied
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.lcd_dat   <= '0;
            bus.lcd_hsync <= ~HS_POL;
            bus.lcd_vsync <= ~VS_POL;
            bus.lcd_den   <= ~DE_POL;
            bus.frame_irq <= 1'b0;
        end else begin
            bus.lcd_dat   <= !de2 ? '0 : (win2 && !pix) ? bus.fg_color : bus.bg_color;
            bus.lcd_hsync <= hs2 ? HS_POL : ~HS_POL;
            bus.lcd_vsync <= vs2 ? VS_POL : ~VS_POL;
            bus.lcd_den   <= de2 ? DE_POL : ~DE_POL;
            bus.frame_irq <= irq2;
        end
    end
endmodule

// File: doc/text_video_gen.md
Name: text_video_gen

Overview:
- Parametrised character-cell video generator, next generation of the fixed 32-column Galaksija text display.
- Contains a dual-port character RAM (CPU port + scan port) and a character-to-glyph mapper feeding a font ROM.
- Generates the pixel stream with configurable raster timing, integer pixel scaling, a border offset, runtime colours, selectable sync/DE polarity and a frame interrupt pulse.
- Sits between the Z80 bus glue and the LCD/DVI output encoder.

Parameters:
COLS, 32, text columns
ROWS, 16, text rows
FONT_LINES, 13, glyph scanlines per cell (1..16)
X_SCALE, 2, horizontal pixel replication (1..4)
Y_SCALE, 2, vertical scanline replication (1..4)
X_OFFSET, 64, first text pixel column in the visible area
Y_OFFSET, 32, first text scanline in the visible area
H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixels
V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines
HS_POL/VS_POL/DE_POL, 0/0/1, asserted level of hsync, vsync and DE
DW, 8, pixel data width
AW, 11, character RAM address width; COLS*ROWS <= 2^AW

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
rd_ram  in  1  CPU read strobe
wr_ram  in  1  CPU write strobe
addr  in  AW  CPU character RAM address
data  in  8  CPU write data
ram_out  out  8  CPU read data, registered
fg_color  in  DW  glyph foreground colour
bg_color  in  DW  glyph background and border colour
lcd_dat  out  DW  pixel data
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_den  out  1  data enable
frame_irq  out  1  one-cycle pulse per frame

Behaviour:
- Reset (synchronous, active-high): all counters 0; lcd_dat 0; syncs and DE at their de-asserted level; frame_irq 0; ram_out 0. RAM contents are not cleared. Asserting reset mid-frame restarts the raster at h=0, v=0 on the next cycle.
- Raster counters:
  - h counts 0..H_total-1; it wraps and increments v.
  - v counts 0..V_total-1, then wraps to 0.
  - hsync is asserted for h in [H_VISIBLE+H_FRONT, +H_SYNC); vsync likewise for v.
  - DE is asserted for h<H_VISIBLE && v<V_VISIBLE.
- Text window:
  - Active where X_OFFSET <= h < X_OFFSET+COLS*8*X_SCALE and Y_OFFSET <= v < Y_OFFSET+ROWS*FONT_LINES*Y_SCALE.
  - Incremental sub-counters (no dividers) track: x-sub 0..X_SCALE-1, pixel bit 0..7, column, y-sub, font line 0..FONT_LINES-1, and a row base stepped by COLS.
  - All sub-counters reset at the window start of each line/frame.
- Character mapping, applied to code c:
  - 64..95 or 128..191 -> c-64
  - >=192 -> c-128
  - otherwise c
  - Font ROM address = {font_line[3:0], char[6:0]}.
- Pipeline, total latency 3 clk from counter to pins:
  - S1: register RAM[row_base+col].
  - S2: font ROM registered lookup.
  - S3: output register.
  - Bit index, window flag, DE and syncs are delayed to match.
- Pixel value:
  - In window: glyph bit[bit_idx] (LSB = leftmost) = 1 -> bg_color, 0 -> fg_color. The ROM stores glyphs inverted.
  - Visible but outside window: bg_color.
  - DE inactive: 0.
- frame_irq: high for exactly one cycle, when the delayed raster reaches h=0, v=V_VISIBLE.
- CPU port:
  - Read latency 1 clk; ram_out holds its value when rd_ram=0.
  - Simultaneous rd and wr to the same address returns the old data.
  - A write and a scan read of the same cell in the same cycle: the scan sees the old data.
- Addresses >= COLS*ROWS are valid RAM storage and are never displayed.

Optional Feature:
TEXT_VIDEO_CURSOR_EN
- With the macro: adds inputs cursor_addr[AW-1:0] and cursor_on.
  - When cursor_on=1 and the scanned cell equals cursor_addr, the glyph bits are inverted.
  - The inversion toggles every 16 frames, driven by a 5-bit frame counter (bit 4) that resets to 0.
- Without the macro: the ports and logic are absent and output is identical to cursor_on=0.

Decomposition:
- Package text_video_pkg holds:
  - timing totals (H_TOTAL, V_TOTAL);
  - the char_map function;
  - the pixel-window width/height constants derived from the parameters.
- One sub-module: font_rom (2048x8, registered output, ports clk, addr[10:0], data_out[7:0]); the existing font image is reused unchanged.

Test Plan:
1. Reset held 5 clk, then released -> first hsync assertion (HS_POL=0, so low) at cycle 3+656 after release; hsync period 800 clk; vsync period 525 lines.
2. CPU writes 0x41 to addr 0, then reads addr 0 -> ram_out=0x41 one clk after rd_ram; same-cycle rd+wr 0x55 to addr 0 -> ram_out=0x41.
3. Write code 200 to cell 0 -> font ROM addr low 7 bits = 72 on every glyph line of cell 0; code 70 -> 6; code 20 -> 20.
4. Fill RAM with 0x20 (blank glyph, all ROM bits 1), fg=0xFF, bg=0x00 -> lcd_dat=0 over the whole visible area and no 0xFF pixel anywhere.
5. Glyph row pattern 0xFE at cell 0 with X_SCALE=2 -> pixels h=64,65 show fg; h=66..79 show bg; DE low at h>=640.
6. frame_irq -> exactly one pulse per 420000 clk; TEXT_VIDEO_CURSOR_EN with cursor_addr=5 -> cell 5 is inverted in frames 16..31, and normal in frames 0..15 and when cursor_on=0.
